// File: rtl/mux_n_reg_pkg.sv
// ---------------------------------------------------------------------------
// mux_n_reg_pkg
//   Shared defaults and helpers for the N:1 registered multiplexer.
//   Contents:
//     MUX_WIDTH_DEF / MUX_N_DEF  default data width and channel count
//     sel_mode_e                 channel-selection mode (fixed sel / round-robin)
//     mux_clog2()                ceil(log2(value)), used to derive the select width
// ---------------------------------------------------------------------------
package mux_n_reg_pkg;

  localparam int MUX_WIDTH_DEF = 8;
  localparam int MUX_N_DEF     = 4;

  typedef enum logic {
    SEL_FIXED = 1'b0,
    SEL_RR    = 1'b1
  } sel_mode_e;

  // Smallest r with 2**r >= value; a value of 1 still needs one select bit.
  function automatic int mux_clog2(input int value);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mux_n_reg_rr_pick.sv
// ---------------------------------------------------------------------------
// mux_n_reg_rr_pick
//   Round-robin channel picker for mux_n_reg (only instantiated when
//   MUX_RR_EN is defined). Holds the rotating priority pointer and finds the
//   first valid channel scanning ptr, ptr+1, ... modulo N.
//   Ports:
//     clk        rising-edge clock
//     rst_n      asynchronous active-low reset, pointer returns to 0
//     in_valid   per-channel valid
//     accept     a word from chan_c is taken this cycle (RR mode only)
//     chan_c     chosen channel index
//     found      at least one channel is valid, chan_c is meaningful
// ---------------------------------------------------------------------------
module mux_n_reg_rr_pick
  import mux_n_reg_pkg::*;
#(
  parameter int N  = MUX_N_DEF,
  parameter int SW = mux_clog2(MUX_N_DEF)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  in_valid,
  input  logic          accept,
  output logic [SW-1:0] chan_c,
  output logic          found
);

  logic [SW-1:0] ptr_q;
  logic [SW-1:0] ptr_d;
  int            idx;

  // Walk the offsets from the far end back to zero so the nearest valid
  // channel after the pointer is the one left standing.
  always_comb begin
    chan_c = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = int'(ptr_q) + k;
      if (idx >= N) idx = idx - N;
      if (in_valid[SW'(idx)]) begin
        chan_c = SW'(idx);
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (accept) begin
      ptr_d = (32'(chan_c) == N - 1) ? '0 : chan_c + SW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/mux_n_reg.sv
// ---------------------------------------------------------------------------
// mux_n_reg
//   N:1 data multiplexer with a one-cycle registered output stage and a
//   valid/ready handshake on both sides. Full throughput: a held word can be
//   drained and replaced in the same cycle.
//
//   Build option: MUX_RR_EN
//     defined   -> rr_mode port present; rr_mode=1 selects the channel
//                  round-robin among valid inputs, rr_mode=0 uses sel.
//     undefined -> fixed selection through sel only.
//
//   Ports:
//     clk        rising-edge clock
//     rst_n      asynchronous active-low reset; clears the output stage
//     in_data    N channels, channel i at [i*WIDTH +: WIDTH]
//     in_valid   per-channel valid
//     in_ready   per-channel ready, at most one bit high
//     sel        channel select in fixed mode; sel >= N selects nothing
//     rr_mode    round-robin enable (MUX_RR_EN builds only)
//     out_data   registered data word
//     out_chan   channel that produced out_data
//     out_valid  out_data/out_chan hold a word
//     out_ready  consumer takes the held word
// ---------------------------------------------------------------------------
module mux_n_reg
  import mux_n_reg_pkg::*;
#(
  parameter int WIDTH = MUX_WIDTH_DEF,
  parameter int N     = MUX_N_DEF,
  parameter int SW    = mux_clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]     in_valid,
  output logic [N-1:0]     in_ready,
  input  logic [SW-1:0]    sel,
`ifdef MUX_RR_EN
  input  logic             rr_mode,
`endif
  output logic [WIDTH-1:0] out_data,
  output logic [SW-1:0]    out_chan,
  output logic             out_valid,
  input  logic             out_ready
);

  logic [WIDTH-1:0] chan_data [N];
  logic [SW-1:0]    chan_c;
  logic             chan_found;
  logic             fix_found;
  logic             can_load;
  logic             cur_valid;
  logic [WIDTH-1:0] cur_data;
  logic             accept;

  logic [WIDTH-1:0] data_q, data_d;
  logic [SW-1:0]    chan_q, chan_d;
  logic             valid_q, valid_d;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      chan_data[i] = in_data[i*WIDTH +: WIDTH];
    end
  end

  // A select value beyond the last channel parks the mux: nothing is chosen.
  assign fix_found = (32'(sel) < N);

`ifdef MUX_RR_EN
  logic [SW-1:0] rr_c;
  logic          rr_found;
  sel_mode_e     mode;

  assign mode = rr_mode ? SEL_RR : SEL_FIXED;

  always_comb begin
    chan_c     = sel;
    chan_found = fix_found;
    if (mode == SEL_RR) begin
      chan_c     = rr_c;
      chan_found = rr_found;
    end
  end

  // The pointer only advances on words taken while in round-robin mode.
  mux_n_reg_rr_pick #(
    .N  (N),
    .SW (SW)
  ) u_rr_pick (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .accept   (accept && (mode == SEL_RR)),
    .chan_c   (rr_c),
    .found    (rr_found)
  );
`else
  assign chan_c     = sel;
  assign chan_found = fix_found;
`endif

  // Room in the output stage: empty, or the held word leaves this cycle.
  assign can_load = !valid_q || out_ready;

  // Ready depends only on selection and room, never on the chosen valid.
  always_comb begin
    in_ready  = '0;
    cur_valid = 1'b0;
    cur_data  = '0;
    for (int i = 0; i < N; i++) begin
      if (chan_found && (32'(chan_c) == i)) begin
        in_ready[i] = can_load;
        cur_valid   = in_valid[i];
        cur_data    = chan_data[i];
      end
    end
  end

  assign accept = cur_valid && can_load;

  always_comb begin
    data_d  = data_q;
    chan_d  = chan_q;
    valid_d = valid_q;
    if (accept) begin
      data_d  = cur_data;
      chan_d  = chan_c;
      valid_d = 1'b1;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      chan_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      chan_q  <= chan_d;
      valid_q <= valid_d;
    end
  end

  assign out_data  = data_q;
  assign out_chan  = chan_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_mux_n_reg.sv
module tb_mux_n_reg;

  localparam int W  = 8;
  localparam int N  = 4;
  localparam int SW = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_ready;
  logic [SW-1:0]  sel;
  logic [W-1:0]   out_data;
  logic [SW-1:0]  out_chan;
  logic           out_valid;
  logic           out_ready;

  logic [3*W-1:0] in_data3;
  logic [2:0]     in_valid3;
  logic [2:0]     in_ready3;
  logic [1:0]     sel3;
  logic [W-1:0]   out_data3;
  logic [1:0]     out_chan3;
  logic           out_valid3;
  logic           out_ready3;

`ifdef MUX_RR_EN
  logic rr_mode;
  logic rr_mode3;
`endif

  mux_n_reg #(.WIDTH(W), .N(N), .SW(SW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sel       (sel),
`ifdef MUX_RR_EN
    .rr_mode   (rr_mode),
`endif
    .out_data  (out_data),
    .out_chan  (out_chan),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  mux_n_reg #(.WIDTH(W), .N(3), .SW(2)) dut3 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data3),
    .in_valid  (in_valid3),
    .in_ready  (in_ready3),
    .sel       (sel3),
`ifdef MUX_RR_EN
    .rr_mode   (rr_mode3),
`endif
    .out_data  (out_data3),
    .out_chan  (out_chan3),
    .out_valid (out_valid3),
    .out_ready (out_ready3)
  );

  // Reference state of the output stage and round-robin pointer.
  bit         m_valid;
  logic [W-1:0] m_data;
  int         m_chan;
  int         m_ptr;

  int n_checks;
  int n_fail;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int model_pick(output bit found);
    found = 1'b0;
`ifdef MUX_RR_EN
    if (rr_mode) begin
      for (int k = 0; k < N; k++) begin
        int idx;
        idx = (m_ptr + k) % N;
        if (in_valid[idx]) begin
          found = 1'b1;
          return idx;
        end
      end
      return 0;
    end
`endif
    if (int'(sel) < N) begin
      found = 1'b1;
      return int'(sel);
    end
    return 0;
  endfunction

  // One clock of the main DUT: check ready mid-cycle, then outputs after the edge.
  task automatic cycle(input string tag);
    int           c;
    bit           found;
    bit           can_load;
    bit           acc;
    logic [N-1:0] exp_rdy;
    @(negedge clk);
    c        = model_pick(found);
    can_load = !m_valid || out_ready;
    exp_rdy  = (found && can_load) ? (N'(1) << c) : '0;
    chk({tag, "_ready"}, 32'(in_ready), 32'(exp_rdy));
    acc = found && can_load && in_valid[c];
    @(posedge clk);
    #1;
    if (acc) begin
      m_valid = 1'b1;
      m_data  = in_data[c*W +: W];
      m_chan  = c;
`ifdef MUX_RR_EN
      if (rr_mode) m_ptr = (c + 1) % N;
`endif
    end else if (out_ready) begin
      m_valid = 1'b0;
    end
    chk({tag, "_valid"}, 32'(out_valid), 32'(m_valid));
    chk({tag, "_data"},  32'(out_data),  32'(m_data));
    chk({tag, "_chan"},  32'(out_chan),  32'(m_chan));
  endtask

  initial begin
    int exp_rr_a [5];
    int exp_rr_b [3];
    n_checks  = 0;
    n_fail    = 0;
    m_valid   = 1'b0;
    m_data    = '0;
    m_chan    = 0;
    m_ptr     = 0;
    rst_n     = 1'b0;
    in_data   = '0;
    in_valid  = '0;
    sel       = '0;
    out_ready = 1'b0;
    in_data3  = '0;
    in_valid3 = '0;
    sel3      = '0;
    out_ready3 = 1'b0;
`ifdef MUX_RR_EN
    rr_mode  = 1'b0;
    rr_mode3 = 1'b0;
`endif

    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data",  32'(out_data),  32'd0);
    chk("rst_chan",  32'(out_chan),  32'd0);
    rst_n = 1'b1;

    // Fixed select of channel 2.
    sel       = 2'd2;
    in_data[2*W +: W] = 8'hA5;
    in_valid  = 4'b0100;
    out_ready = 1'b1;
    cycle("t2");
    chk("t2_const_data",  32'(out_data),  32'hA5);
    chk("t2_const_chan",  32'(out_chan),  32'd2);
    chk("t2_const_valid", 32'(out_valid), 32'd1);

    // Backpressure: held word must not move while sel wanders.
    out_ready = 1'b0;
    in_valid  = 4'b0001;
    in_data[0 +: W] = 8'h3C;
    cycle("t3a");
    sel = 2'd1;
    cycle("t3b");
    sel = 2'd0;
    cycle("t3c");
    chk("t3_hold_data", 32'(out_data), 32'hA5);
    out_ready = 1'b1;
    cycle("t3d");
    chk("t3_ch0_data", 32'(out_data), 32'h3C);
    chk("t3_ch0_chan", 32'(out_chan), 32'd0);

    // Streaming at full rate on channel 1.
    sel      = 2'd1;
    in_valid = 4'b0010;
    for (int d = 1; d <= 4; d++) begin
      in_data[W +: W] = W'(d);
      cycle("t4");
      chk("t4_stream_data",  32'(out_data),  32'(d));
      chk("t4_stream_valid", 32'(out_valid), 32'd1);
    end
    in_valid = '0;
    cycle("t4_drain");
    chk("t4_drained", 32'(out_valid), 32'd0);

    // Three-channel instance: select 3 chooses nothing.
    sel3       = 2'd3;
    in_valid3  = 3'b111;
    in_data3   = 24'h5A_77_11;
    out_ready3 = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("t5_ready_none", 32'(in_ready3), 32'd0);
      @(posedge clk);
      #1;
      chk("t5_no_valid", 32'(out_valid3), 32'd0);
    end
    sel3 = 2'd2;
    @(negedge clk);
    chk("t5_ready_ch2", 32'(in_ready3), 32'b100);
    @(posedge clk);
    #1;
    chk("t5_valid_ch2", 32'(out_valid3), 32'd1);
    chk("t5_data_ch2",  32'(out_data3),  32'h5A);
    chk("t5_chan_ch2",  32'(out_chan3),  32'd2);
    in_valid3 = '0;

`ifdef MUX_RR_EN
    // Round-robin: pointer still 0 since reset (fixed mode leaves it alone).
    exp_rr_a = '{0, 1, 2, 3, 0};
    exp_rr_b = '{1, 3, 1};
    rr_mode   = 1'b1;
    out_ready = 1'b1;
    in_data   = 32'h13_12_11_10;
    in_valid  = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      cycle("t6a");
      chk("t6a_rr_chan", 32'(out_chan), 32'(exp_rr_a[k]));
    end
    in_valid = 4'b1010;
    for (int k = 0; k < 3; k++) begin
      cycle("t6b");
      chk("t6b_rr_chan", 32'(out_chan), 32'(exp_rr_b[k]));
    end
    rr_mode = 1'b0;
`endif

    // Asynchronous reset in the middle of traffic.
    sel       = 2'd1;
    in_valid  = 4'b0010;
    in_data[W +: W] = 8'hC7;
    out_ready = 1'b1;
    cycle("t1_load");
    #2;
    rst_n = 1'b0;
    #1;
    chk("t1_valid", 32'(out_valid), 32'd0);
    chk("t1_data",  32'(out_data),  32'd0);
    chk("t1_chan",  32'(out_chan),  32'd0);
    m_valid = 1'b0;
    m_data  = '0;
    m_chan  = 0;
    m_ptr   = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Random traffic against the reference model.
    for (int t = 0; t < 400; t++) begin
      in_data   = $urandom;
      in_valid  = N'($urandom_range(0, 15));
      sel       = SW'($urandom_range(0, 3));
      out_ready = ($urandom_range(0, 3) != 0);
`ifdef MUX_RR_EN
      rr_mode   = $urandom_range(0, 1) == 1;
`endif
      cycle("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
